// File: rtl/fifo_serializer.sv
// Reads words from an upstream FIFO and sends each one as a serial frame on tx.
// Frame layout: start bit, data bits LSB first, optional even parity bit, stop bit.
module fifo_serializer #(
    parameter int FIFO_WIDTH   = 16,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underflow_err,
    output logic [7:0]            frame_cnt,
    output logic [2:0]            dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    localparam int               IDX_W     = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
    localparam logic [7:0]       LAST_TICK = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0]       DONE_TICK = 8'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(FIFO_WIDTH - 1);

    logic [2:0]            r_state;
    logic [FIFO_WIDTH-1:0] r_shift;
    logic [7:0]            r_clk_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_underflow_err;
    logic [7:0]            r_frame_cnt;

    logic                  w_rd_en;
    logic                  w_tick_last;
    logic [FIFO_WIDTH-1:0] w_shift_next;

    // The read strobe only exists in IDLE, and IDLE always lasts one cycle once it fires,
    // so it can never be high on two consecutive cycles.
    assign w_rd_en      = rst_n && (r_state == S_IDLE) && enable && !fifo_empty;
    assign w_tick_last  = (r_clk_cnt == LAST_TICK);
    assign w_shift_next = r_shift >> 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_shift         <= '0;
            r_clk_cnt       <= '0;
            r_bit_idx       <= '0;
            r_parity        <= 1'b0;
            r_tx            <= 1'b1;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
            r_underflow_err <= 1'b0;
            r_frame_cnt     <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_rd_en) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (fifo_underflow) begin
                        r_underflow_err <= 1'b1;
                        r_state         <= S_IDLE;
                        r_busy          <= 1'b0;
                    end else begin
                        r_shift   <= fifo_data_out;
                        r_parity  <= ^fifo_data_out;
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick_last) begin
                        r_clk_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (w_tick_last) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= w_shift_next;
                            r_tx      <= w_shift_next[0];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 8'd1;
                    end
                end
                S_PARITY: begin
                    if (w_tick_last) begin
                        r_clk_cnt <= '0;
                        r_tx      <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 8'd1;
                    end
                end
                S_STOP: begin
                    // frame_done is registered, so it is raised one tick early to land on the last STOP cycle.
                    if (w_tick_last) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 8'd1;
                        if (r_clk_cnt == DONE_TICK) begin
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign fifo_rd_en    = w_rd_en;
    assign tx            = r_tx;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;
    assign underflow_err = r_underflow_err;
    assign frame_cnt     = r_frame_cnt;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench for fifo_serializer (16-bit words, 4 clocks per bit, even parity).
// A small FIFO model answers read strobes; each test task checks its own results.
module tb_fifo_serializer;

    localparam int W         = 16;
    localparam int CPB       = 4;
    localparam int FRAME_CYC = 76;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         fifo_empty;
    logic         fifo_underflow;
    logic [W-1:0] fifo_data_out;
    logic         fifo_rd_en;
    logic         tx;
    logic         busy;
    logic         frame_done;
    logic         underflow_err;
    logic [7:0]   frame_cnt;
    logic [2:0]   dbg_state;

    fifo_serializer #(
        .FIFO_WIDTH  (W),
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_underflow(fifo_underflow),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done),
        .underflow_err (underflow_err),
        .frame_cnt     (frame_cnt),
        .dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [W-1:0] fifo_q[$];
    int           rd_pulses   = 0;
    int           rd_consec   = 0;
    int           rd_in_reset = 0;

    // FIFO model: a read seen in cycle N presents its word from just after the next edge.
    initial begin
        logic         rd_prev;
        logic         rd_now;
        logic [W-1:0] pend;
        rd_prev       = 1'b0;
        pend          = '0;
        fifo_empty    = 1'b1;
        fifo_data_out = '0;
        forever begin
            @(negedge clk);
            #1;
            rd_now = (fifo_rd_en === 1'b1);
            if (rd_now) begin
                rd_pulses++;
                if (rd_prev) rd_consec++;
                if (rst_n !== 1'b1) rd_in_reset++;
                pend = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
            end
            rd_prev = rd_now;
            @(posedge clk);
            #1;
            if (rd_now) fifo_data_out = pend;
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    logic [18:0] cap_bits;
    int          cap_unstable;
    int          cap_done_cnt;
    int          cap_done_pos;
    int          cap_busy_bad;
    logic        post_tx;
    logic        post_busy;
    logic        post_done;
    logic [7:0]  post_cnt;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_start(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (tx === 1'b0) ok = 1'b1;
        end
    endtask

    // Samples one whole frame starting at the negedge already holding the first start cycle.
    task automatic capture_frame(input int drop_cycle);
        cap_bits     = '0;
        cap_unstable = 0;
        cap_done_cnt = 0;
        cap_done_pos = -1;
        cap_busy_bad = 0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0) @(negedge clk);
            if (c == drop_cycle) enable = 1'b0;
            if (c % CPB == 0) cap_bits[c / CPB] = tx;
            else if (tx !== cap_bits[c / CPB]) cap_unstable++;
            if (frame_done === 1'b1) begin
                cap_done_cnt++;
                cap_done_pos = c;
            end
            if (busy !== 1'b1) cap_busy_bad++;
        end
        @(negedge clk);
        post_tx   = tx;
        post_busy = busy;
        post_done = frame_done;
        post_cnt  = frame_cnt;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", frame_done); end
        n_cmp++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_uerr: got %b expected 0", underflow_err); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", frame_cnt); end
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b expected 0", fifo_rd_en); end
        n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_word();
        bit          ok;
        int          n;
        int          rd0;
        logic [18:0] exp;
        do_reset();
        rd0 = rd_pulses;
        fifo_q.push_back(16'hA5C3);
        enable = 1'b1;
        wait_start(ok, n);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_start: got no start bit expected one within 300 cycles"); end
        capture_frame(-1);
        exp = {1'b1, 1'b0, 16'hA5C3, 1'b0};
        n_cmp++; if (cap_bits !== exp) begin n_fail++; $display("FAIL single_bits: got %h expected %h", cap_bits, exp); end
        n_cmp++; if (cap_unstable != 0) begin n_fail++; $display("FAIL single_bit_width: got %0d glitches expected 0", cap_unstable); end
        n_cmp++; if (cap_done_cnt != 1 || cap_done_pos != 75) begin n_fail++; $display("FAIL single_done: got %0d pulses at %0d expected 1 at 75", cap_done_cnt, cap_done_pos); end
        n_cmp++; if (cap_busy_bad != 0) begin n_fail++; $display("FAIL single_busy: got %0d idle cycles expected 0", cap_busy_bad); end
        n_cmp++; if (post_tx !== 1'b1 || post_busy !== 1'b0 || post_done !== 1'b0) begin n_fail++; $display("FAIL single_after: got tx=%b busy=%b done=%b expected 1 0 0", post_tx, post_busy, post_done); end
        n_cmp++; if (post_cnt !== 8'd1) begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", post_cnt); end
        n_cmp++; if (rd_pulses - rd0 != 1) begin n_fail++; $display("FAIL single_rd: got %0d reads expected 1", rd_pulses - rd0); end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int          n;
        int          rd0;
        logic [18:0] exp;
        do_reset();
        rd0 = rd_pulses;
        fifo_q.push_back(16'h0001);
        fifo_q.push_back(16'hFFFF);
        enable = 1'b1;
        wait_start(ok, n);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_start1: got no start bit expected one within 300 cycles"); end
        capture_frame(-1);
        exp = {1'b1, 1'b1, 16'h0001, 1'b0};
        n_cmp++; if (cap_bits !== exp) begin n_fail++; $display("FAIL b2b_bits1: got %h expected %h", cap_bits, exp); end
        n_cmp++; if (post_tx !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: got tx=%b expected 1", post_tx); end
        wait_start(ok, n);
        n_cmp++; if (!ok || n != 2) begin n_fail++; $display("FAIL b2b_gap_len: got %0d more cycles expected 2", n); end
        capture_frame(-1);
        exp = {1'b1, 1'b0, 16'hFFFF, 1'b0};
        n_cmp++; if (cap_bits !== exp) begin n_fail++; $display("FAIL b2b_bits2: got %h expected %h", cap_bits, exp); end
        n_cmp++; if (cap_unstable != 0 || cap_done_pos != 75) begin n_fail++; $display("FAIL b2b_timing2: got %0d glitches done at %0d expected 0 and 75", cap_unstable, cap_done_pos); end
        n_cmp++; if (post_cnt !== 8'd2) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 2", post_cnt); end
        n_cmp++; if (rd_pulses - rd0 != 2) begin n_fail++; $display("FAIL b2b_rd: got %0d reads expected 2", rd_pulses - rd0); end
    endtask

    task automatic test_empty_fifo();
        int bad;
        do_reset();
        enable = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL empty_idle: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_enable_drop();
        bit          ok;
        int          n;
        int          rd0;
        int          bad;
        logic [18:0] exp;
        do_reset();
        rd0 = rd_pulses;
        fifo_q.push_back(16'h1234);
        fifo_q.push_back(16'h5678);
        enable = 1'b1;
        wait_start(ok, n);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL drop_start: got no start bit expected one within 300 cycles"); end
        capture_frame(25);
        exp = {1'b1, 1'b1, 16'h1234, 1'b0};
        n_cmp++; if (cap_bits !== exp || cap_unstable != 0) begin n_fail++; $display("FAIL drop_frame: got %h (%0d glitches) expected %h", cap_bits, cap_unstable, exp); end
        n_cmp++; if (cap_done_cnt != 1) begin n_fail++; $display("FAIL drop_done: got %0d pulses expected 1", cap_done_cnt); end
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0 || rd_pulses - rd0 != 1) begin n_fail++; $display("FAIL drop_hold: got %0d active cycles %0d reads expected 0 and 1", bad, rd_pulses - rd0); end
        enable = 1'b1;
        wait_start(ok, n);
        capture_frame(-1);
        exp = {1'b1, 1'b0, 16'h5678, 1'b0};
        n_cmp++; if (!ok || cap_bits !== exp) begin n_fail++; $display("FAIL drop_resume: got %h expected %h", cap_bits, exp); end
        n_cmp++; if (post_cnt !== 8'd2) begin n_fail++; $display("FAIL drop_cnt: got %0d expected 2", post_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        bit          ok;
        int          n;
        int          bad;
        logic [18:0] exp;
        do_reset();
        fifo_q.push_back(16'h0F0F);
        enable = 1'b1;
        wait_start(ok, n);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_start: got no start bit expected one within 300 cycles"); end
        fifo_q.push_back(16'h8001);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort: got tx=%b busy=%b expected 1 0", tx, busy); end
        n_cmp++; if (frame_cnt !== 8'd0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_cnt: got cnt=%0d done=%b expected 0 0", frame_cnt, frame_done); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (fifo_rd_en !== 1'b0) bad++;
            if (i < 3) @(negedge clk);
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_rd: got %0d strobes in reset expected 0", bad); end
        rst_n = 1'b1;
        wait_start(ok, n);
        capture_frame(-1);
        exp = {1'b1, 1'b0, 16'h8001, 1'b0};
        n_cmp++; if (!ok || cap_bits !== exp) begin n_fail++; $display("FAIL rstmid_next: got %h expected %h", cap_bits, exp); end
        n_cmp++; if (post_cnt !== 8'd1) begin n_fail++; $display("FAIL rstmid_cnt_after: got %0d expected 1", post_cnt); end
    endtask

    task automatic test_underflow_and_wrap();
        int         rd0;
        int         bad;
        int         seen;
        bit         pending;
        bit         got256;
        logic [7:0] c255;
        logic [7:0] c256;
        do_reset();
        rd0 = rd_pulses;
        fifo_underflow = 1'b1;
        fifo_q.push_back(16'hFFFF);
        enable = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        fifo_underflow = 1'b0;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL uflow_no_start: got %0d low cycles expected 0", bad); end
        n_cmp++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uflow_err: got %b expected 1", underflow_err); end
        n_cmp++; if (busy !== 1'b0 || dbg_state !== 3'd0 || frame_cnt !== 8'd0) begin n_fail++; $display("FAIL uflow_idle: got busy=%b state=%0d cnt=%0d expected 0 0 0", busy, dbg_state, frame_cnt); end
        n_cmp++; if (rd_pulses - rd0 != 1) begin n_fail++; $display("FAIL uflow_rd: got %0d reads expected 1", rd_pulses - rd0); end
        for (int i = 0; i < 256; i++) fifo_q.push_back(16'h0000);
        seen = 0; pending = 1'b0; got256 = 1'b0; c255 = 8'hxx; c256 = 8'hxx;
        for (int i = 0; i < 256 * 80 + 500 && !got256; i++) begin
            @(negedge clk);
            if (pending) begin
                if (seen == 255) c255 = frame_cnt;
                if (seen == 256) begin c256 = frame_cnt; got256 = 1'b1; end
                pending = 1'b0;
            end
            if (frame_done === 1'b1) begin seen++; pending = 1'b1; end
        end
        n_cmp++; if (!got256) begin n_fail++; $display("FAIL wrap_frames: got %0d frames expected 256", seen); end
        n_cmp++; if (c255 !== 8'd255) begin n_fail++; $display("FAIL wrap_cnt255: got %0d expected 255", c255); end
        n_cmp++; if (c256 !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt0: got %0d expected 0", c256); end
        n_cmp++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uflow_sticky: got %b expected 1", underflow_err); end
        do_reset();
        @(negedge clk);
        n_cmp++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL uflow_clear: got %b expected 0", underflow_err); end
    endtask

    task automatic test_rd_protocol();
        n_cmp++; if (rd_consec != 0) begin n_fail++; $display("FAIL rd_consecutive: got %0d expected 0", rd_consec); end
        n_cmp++; if (rd_in_reset != 0) begin n_fail++; $display("FAIL rd_during_reset: got %0d expected 0", rd_in_reset); end
    endtask

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b0;
        fifo_underflow = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_empty_fifo();
        test_enable_drop();
        test_reset_mid_frame();
        test_underflow_and_wrap();
        test_rd_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
